// File: rtl/multicycle_adder_if.sv
// Operand/result bundle for the digit-serial adder: start/busy/done handshake,
// operands in, result and flags out.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry, overflow, zero, negative
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry, overflow, zero, negative
  );
endinterface

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice walks the operands
// LSB-first over WIDTH/DIGIT cycles through a registered carry.
module multicycle_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIGIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_adder_if.slave   bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_cy, w_cy_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_neg, w_neg_nxt;

  logic [DIGIT:0]   w_sum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_acc_shift;

  // Digit slice; carry into the slice MSB is recovered from its sum bit.
  assign w_sum       = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_cy);
  assign w_cin_msb   = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
  assign w_acc_shift = (r_acc >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_acc_nxt    = r_acc;
    w_result_nxt = r_result;
    w_cnt_nxt    = r_cnt;
    w_cy_nxt     = r_cy;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_carry_nxt  = r_carry;
    w_ovf_nxt    = r_ovf;
    w_zero_nxt   = r_zero;
    w_neg_nxt    = r_neg;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_busy_nxt  = 1'b1;
          w_a_nxt     = bus.a;
          w_b_nxt     = bus.sub ? ~bus.b : bus.b;
          w_cy_nxt    = bus.sub;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end
      RUN: begin
        w_a_nxt   = r_a >> DIGIT;
        w_b_nxt   = r_b >> DIGIT;
        w_acc_nxt = w_acc_shift;
        w_cy_nxt  = w_sum[DIGIT];
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) begin
          w_state_nxt  = IDLE;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_result_nxt = w_acc_shift;
          w_carry_nxt  = w_sum[DIGIT];
          w_ovf_nxt    = w_cin_msb ^ w_sum[DIGIT];
          w_zero_nxt   = (w_acc_shift == '0);
          w_neg_nxt    = w_acc_shift[WIDTH-1];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_cy     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_acc    <= w_acc_nxt;
      r_result <= w_result_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cy     <= w_cy_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_carry  <= w_carry_nxt;
      r_ovf    <= w_ovf_nxt;
      r_zero   <= w_zero_nxt;
      r_neg    <= w_neg_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
  assign bus.negative = r_neg;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and randomized checks of multicycle_adder across several WIDTH/DIGIT splits.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(64)) m_if ();
  multicycle_adder_if #(.WIDTH(64)) d1_if ();
  multicycle_adder_if #(.WIDTH(64)) d64_if ();
  multicycle_adder_if #(.WIDTH(8))  w8_if ();

  multicycle_adder #(.WIDTH(64), .DIGIT(4))  u_dut (.clk(clk), .reset(reset), .bus(m_if));
  multicycle_adder #(.WIDTH(64), .DIGIT(1))  u_d1  (.clk(clk), .reset(reset), .bus(d1_if));
  multicycle_adder #(.WIDTH(64), .DIGIT(64)) u_d64 (.clk(clk), .reset(reset), .bus(d64_if));
  multicycle_adder #(.WIDTH(8),  .DIGIT(2))  u_w8  (.clk(clk), .reset(reset), .bus(w8_if));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {carry, overflow, zero, negative}
  function automatic logic [67:0] model64(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [64:0] t;
    logic [63:0] bb;
    logic        ovf;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + 65'(s);
    ovf = (a[63] == bb[63]) && (t[63] != a[63]);
    return {t[64], ovf, t[63:0] == 64'd0, t[63], t[63:0]};
  endfunction

  function automatic logic [11:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [8:0] t;
    logic [7:0] bb;
    logic       ovf;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + 9'(s);
    ovf = (a[7] == bb[7]) && (t[7] != a[7]);
    return {t[8], ovf, t[7:0] == 8'd0, t[7], t[7:0]};
  endfunction

  // Called #1 after an edge with the DUT idle (or in its done cycle).
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input int poke_at,
                        input logic [63:0] exp_res, input logic [3:0] exp_fl);
    int lat;
    m_if.a = a; m_if.b = b; m_if.sub = s; m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    lat = 0;
    check({tag, "_busy"}, 64'(m_if.busy), 64'd1);
    check({tag, "_done_lo"}, 64'(m_if.done), 64'd0);
    while (!m_if.done && lat < 40) begin
      if (lat == poke_at) begin
        m_if.a = ~a; m_if.b = 64'h1234; m_if.sub = ~s; m_if.start = 1'b1;
      end
      @(posedge clk); #1;
      m_if.start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check({tag, "_res"}, m_if.result, exp_res);
    check({tag, "_flags"}, 64'({m_if.carry, m_if.overflow, m_if.zero, m_if.negative}), 64'(exp_fl));
  endtask

  task automatic sweep(input int iters);
    for (int i = 0; i < iters; i++) begin
      logic [63:0] a, b, r1, r64;
      logic [7:0]  r8;
      logic [3:0]  f1, f64, f8;
      logic        s, g1, g64, g8;
      logic [67:0] e64;
      logic [11:0] e8;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      if (i % 4 == 0) b = a;
      if (i % 8 == 1) a = 64'h7FFF_FFFF_FFFF_FFFF;
      g1 = 1'b0; g64 = 1'b0; g8 = 1'b0;
      r1 = '0; r64 = '0; r8 = '0; f1 = '0; f64 = '0; f8 = '0;
      d1_if.a  = a; d1_if.b  = b; d1_if.sub  = s; d1_if.start  = 1'b1;
      d64_if.a = a; d64_if.b = b; d64_if.sub = s; d64_if.start = 1'b1;
      w8_if.a  = a[7:0]; w8_if.b = b[7:0]; w8_if.sub = s; w8_if.start = 1'b1;
      @(posedge clk); #1;
      d1_if.start = 1'b0; d64_if.start = 1'b0; w8_if.start = 1'b0;
      for (int c = 0; c < 80 && !(g1 && g64 && g8); c++) begin
        @(posedge clk); #1;
        if (d1_if.done && !g1) begin
          g1 = 1'b1; r1 = d1_if.result;
          f1 = {d1_if.carry, d1_if.overflow, d1_if.zero, d1_if.negative};
        end
        if (d64_if.done && !g64) begin
          g64 = 1'b1; r64 = d64_if.result;
          f64 = {d64_if.carry, d64_if.overflow, d64_if.zero, d64_if.negative};
        end
        if (w8_if.done && !g8) begin
          g8 = 1'b1; r8 = w8_if.result;
          f8 = {w8_if.carry, w8_if.overflow, w8_if.zero, w8_if.negative};
        end
      end
      e64 = model64(a, b, s);
      e8  = model8(a[7:0], b[7:0], s);
      check("d1_done",   64'(g1),  64'd1);
      check("d1_res",    r1,       e64[63:0]);
      check("d1_flags",  64'(f1),  64'(e64[67:64]));
      check("d64_done",  64'(g64), 64'd1);
      check("d64_res",   r64,      e64[63:0]);
      check("d64_flags", 64'(f64), 64'(e64[67:64]));
      check("w8_done",   64'(g8),  64'd1);
      check("w8_res",    64'(r8),  64'(e8[7:0]));
      check("w8_flags",  64'(f8),  64'(e8[11:8]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit expired, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    m_if.start = 1'b0;   m_if.sub = 1'b0;   m_if.a = '0;   m_if.b = '0;
    d1_if.start = 1'b0;  d1_if.sub = 1'b0;  d1_if.a = '0;  d1_if.b = '0;
    d64_if.start = 1'b0; d64_if.sub = 1'b0; d64_if.a = '0; d64_if.b = '0;
    w8_if.start = 1'b0;  w8_if.sub = 1'b0;  w8_if.a = '0;  w8_if.b = '0;

    // Reset held with start asserted
    reset = 1'b0;
    m_if.start = 1'b1; m_if.a = 64'd9; m_if.b = 64'd9;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_busy",  64'(m_if.busy), 64'd0);
      check("rst_done",  64'(m_if.done), 64'd0);
      check("rst_res",   m_if.result,    64'd0);
      check("rst_flags", 64'({m_if.carry, m_if.overflow, m_if.zero, m_if.negative}), 64'd0);
    end
    reset = 1'b1;
    m_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(m_if.busy), 64'd0);

    run_op("add_basic", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, -1, 64'h0000_0001_0000_0000, 4'b0000);
    @(posedge clk); #1;
    check("done_pulse", 64'(m_if.done), 64'd0);
    run_op("add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1, 64'd0, 4'b1010);
    run_op("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1, 64'h8000_0000_0000_0000, 4'b0101);
    run_op("sub_eq",    64'd5, 64'd5, 1'b1, -1, 64'd0, 4'b1010);
    run_op("sub_neg",   64'd3, 64'd5, 1'b1, -1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001);
    run_op("sub_ovf",   64'h8000_0000_0000_0000, 64'd1, 1'b1, -1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    run_op("sub_zero",  64'd0, 64'd0, 1'b1, -1, 64'd0, 4'b1010);
    run_op("busy_poke", 64'h10, 64'h20, 1'b0, 5, 64'h30, 4'b0000);
    // Second operation started in the done cycle of the first
    run_op("b2b_a",     64'd3, 64'd4, 1'b0, -1, 64'd7, 4'b0000);
    run_op("b2b_b",     64'h123, 64'h100, 1'b0, -1, 64'h223, 4'b0000);

    // Abort mid-operation
    @(posedge clk); #1;
    m_if.a = 64'd1; m_if.b = 64'd2; m_if.sub = 1'b0; m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_busy", 64'(m_if.busy), 64'd0);
    check("abort_res",  m_if.result,    64'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_if.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_res_hold", m_if.result, 64'd0);

    sweep(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
